// File: rtl/mesh_rd_initiator.sv
// West-edge read initiator for one SRAM-bank mesh row: tags reads with ROB slot ids and
// hands the (possibly out-of-order) returning beats back to the client in request order.
module mesh_rd_initiator #(
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 16,
  parameter int RAM_ID_W = 4,
  parameter int DATA_W   = 512,
  parameter int TO_CYC   = 1023,
  localparam int TXN_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_vld,
  output logic                req_rdy,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [RAM_ID_W-1:0] req_ram_id,
  output logic                cmd_vld,
  output logic [ADDR_W-1:0]   cmd_addr,
  output logic [RAM_ID_W-1:0] cmd_ram_id,
  output logic [TXN_W-1:0]    cmd_txn_id,
  input  logic                dat_vld,
  input  logic [TXN_W-1:0]    dat_txn_id,
  input  logic [DATA_W-1:0]   dat_data,
  output logic                rsp_vld,
  input  logic                rsp_rdy,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                err_unexp,
  output logic                err_timeout,
  output logic [TXN_W:0]      outstanding
);

  localparam int TO_W = $clog2(TO_CYC + 1);
  localparam logic [TXN_W:0]  PTR_ONE = {{TXN_W{1'b0}}, 1'b1};
  localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TO_CYC);

  logic [TXN_W:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0]      pend_q, pend_d, done_q, done_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic                  cmd_vld_q, cmd_vld_d;
  logic [ADDR_W-1:0]     cmd_addr_q, cmd_addr_d;
  logic [RAM_ID_W-1:0]   cmd_ram_id_q, cmd_ram_id_d;
  logic [TXN_W-1:0]      cmd_txn_id_q, cmd_txn_id_d;
  logic                  err_unexp_q, err_unexp_d;
  logic                  err_timeout_q, err_timeout_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;

  logic [TXN_W-1:0]      wr_idx, rd_idx;
  logic                  full, empty, alloc, pop, beat_ok;

  assign wr_idx  = wr_ptr_q[TXN_W-1:0];
  assign rd_idx  = rd_ptr_q[TXN_W-1:0];
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[TXN_W] != rd_ptr_q[TXN_W]) && (wr_idx == rd_idx);
  // Slot freedom comes only from registered pointers, so a same-cycle pop never admits a request.
  assign req_rdy = !full;
  assign alloc   = req_vld && !full;
  assign rsp_vld = done_q[rd_idx];
  assign pop     = rsp_vld && rsp_rdy;
  assign beat_ok = dat_vld && pend_q[dat_txn_id] && !done_q[dat_txn_id];

  assign rsp_data    = rsp_vld ? mem_q[rd_idx] : {DATA_W{1'b0}};
  assign cmd_vld     = cmd_vld_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_ram_id  = cmd_ram_id_q;
  assign cmd_txn_id  = cmd_txn_id_q;
  assign err_unexp   = err_unexp_q;
  assign err_timeout = err_timeout_q;
  assign outstanding = wr_ptr_q - rd_ptr_q;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pend_d        = pend_q;
    done_d        = done_q;
    cmd_vld_d     = alloc;
    cmd_addr_d    = cmd_addr_q;
    cmd_ram_id_d  = cmd_ram_id_q;
    cmd_txn_id_d  = cmd_txn_id_q;
    err_unexp_d   = dat_vld && !beat_ok;
    err_timeout_d = err_timeout_q;
    to_cnt_d      = to_cnt_q;

    if (beat_ok) begin
      done_d[dat_txn_id] = 1'b1;
    end else begin
      done_d = done_d;
    end

    if (pop) begin
      pend_d[rd_idx] = 1'b0;
      done_d[rd_idx] = 1'b0;
      rd_ptr_d       = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Alloc and pop never target the same slot: that would need the ROB both full and empty.
    if (alloc) begin
      pend_d[wr_idx] = 1'b1;
      done_d[wr_idx] = 1'b0;
      wr_ptr_d       = wr_ptr_q + PTR_ONE;
      cmd_addr_d     = req_addr;
      cmd_ram_id_d   = req_ram_id;
      cmd_txn_id_d   = wr_idx;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop || empty || done_q[rd_idx]) begin
      to_cnt_d = {TO_W{1'b0}};
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + TO_ONE;
    end else begin
      to_cnt_d = to_cnt_q;
    end

    if (to_cnt_q == TO_MAX) begin
      err_timeout_d = 1'b1;
    end else begin
      err_timeout_d = err_timeout_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= {(TXN_W+1){1'b0}};
      rd_ptr_q      <= {(TXN_W+1){1'b0}};
      pend_q        <= {DEPTH{1'b0}};
      done_q        <= {DEPTH{1'b0}};
      cmd_vld_q     <= 1'b0;
      cmd_addr_q    <= {ADDR_W{1'b0}};
      cmd_ram_id_q  <= {RAM_ID_W{1'b0}};
      cmd_txn_id_q  <= {TXN_W{1'b0}};
      err_unexp_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      to_cnt_q      <= {TO_W{1'b0}};
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pend_q        <= pend_d;
      done_q        <= done_d;
      cmd_vld_q     <= cmd_vld_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_ram_id_q  <= cmd_ram_id_d;
      cmd_txn_id_q  <= cmd_txn_id_d;
      err_unexp_q   <= err_unexp_d;
      err_timeout_q <= err_timeout_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  // Data storage is left unreset; done bits gate every read of it.
  always_ff @(posedge clk) begin
    if (beat_ok) begin
      mem_q[dat_txn_id] <= dat_data;
    end
  end

endmodule
